// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int         SEQ_DET_DEF_PAT_W   = 4;
    localparam logic [3:0] SEQ_DET_DEF_PATTERN = 4'b1010;
    localparam int         SEQ_DET_DEF_CNT_W   = 8;

    // Width needed to count 0..pat_w collected history bits.
    function automatic int seq_det_fill_w(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky flag that rises when the count reaches all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (&v) ? v : v + W'(1);
    endfunction

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr_i) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc_i) begin
            count_d = sat_inc(count_q);
            sat_d   = sat_q | (&count_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with overlap control and saturating match counter.
// Optional runtime pattern loading is enabled by defining SEQ_DET_PATTERN_LOAD_EN.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = SEQ_DET_DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(SEQ_DET_DEF_PATTERN),
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = SEQ_DET_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
`ifdef SEQ_DET_PATTERN_LOAD_EN
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
`endif
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int FILL_W = seq_det_fill_w(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d, nh;
    logic [FILL_W-1:0] fill_q, fill_d, nf;
    logic [PAT_W-1:0]  pattern;
    logic              z_q, z_d;
    logic              load;
    logic              hit;

`ifdef SEQ_DET_PATTERN_LOAD_EN
    logic [PAT_W-1:0] pat_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= PATTERN;
        end else if (!clr && pat_load) begin
            pat_q <= pat_in;
        end
    end

    assign pattern = pat_q;
    assign load    = pat_load;
`else
    assign pattern = PATTERN;
    assign load    = 1'b0;
`endif

    assign nh  = {hist_q[PAT_W-2:0], x};
    assign nf  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + FILL_W'(1);
    // Fill gating keeps stale zeros in hist from matching all-zero patterns.
    assign hit = en && !clr && !load && (nf == FILL_W'(PAT_W)) && (nh == pattern);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        if (clr || load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = nh;
            fill_d = (hit && (OVERLAP == 0)) ? '0 : nf;
            z_d    = hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z = z_q;

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (clr),
        .inc_i  (hit),
        .count_o(match_count),
        .sat_o  (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (overlap, non-overlap, 2-bit counter) vs a stream model.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic       x = 1'b0;
    logic       pat_load = 1'b0;
    logic [3:0] pat_in = 4'b0;

    logic       z_a, z_b, z_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.OVERLAP(1)) dut_a (
        .clk(clk), .reset(rst_n), .clr(clr), .en(en), .x(x),
`ifdef SEQ_DET_PATTERN_LOAD_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .z(z_a), .match_count(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector_param #(.OVERLAP(0)) dut_b (
        .clk(clk), .reset(rst_n), .clr(clr), .en(en), .x(x),
`ifdef SEQ_DET_PATTERN_LOAD_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .z(z_b), .match_count(cnt_b), .cnt_sat(sat_b)
    );

    seq_detector_param #(.OVERLAP(1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(rst_n), .clr(clr), .en(en), .x(x),
`ifdef SEQ_DET_PATTERN_LOAD_EN
        .pat_load(pat_load), .pat_in(pat_in),
`endif
        .z(z_c), .match_count(cnt_c), .cnt_sat(sat_c)
    );

    logic       zv[3];
    logic [7:0] cv[3];
    logic       sv[3];
    assign zv[0] = z_a;  assign cv[0] = cnt_a;        assign sv[0] = sat_a;
    assign zv[1] = z_b;  assign cv[1] = cnt_b;        assign sv[1] = sat_b;
    assign zv[2] = z_c;  assign cv[2] = {6'b0, cnt_c}; assign sv[2] = sat_c;

    // Reference model: all enabled bits since reset/clr, plus per-instance flush point.
    bit       stream[$];
    int       start[3];
    bit       mz[3];
    int       mc[3];
    bit       ms[3];
    int       cmax[3] = '{255, 255, 3};
    bit       movl[3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] mpat = 4'b1010;

    function automatic bit tail_match(input int k);
        int n;
        n = stream.size();
        if (n - start[k] < 4) return 1'b0;
        for (int i = 0; i < 4; i++)
            if (stream[n-4+i] != mpat[3-i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        stream.delete();
        for (int k = 0; k < 3; k++) begin
            start[k] = 0; mz[k] = 0; mc[k] = 0; ms[k] = 0;
        end
    endtask

    task automatic model_edge(input bit c, input bit e, input bit b, input bit l, input logic [3:0] p);
        if (c) begin
            model_reset();
        end else if (l) begin
            mpat = p;
            for (int k = 0; k < 3; k++) begin
                start[k] = stream.size(); mz[k] = 0;
            end
        end else if (e) begin
            stream.push_back(b);
            for (int k = 0; k < 3; k++) begin
                mz[k] = tail_match(k);
                if (mz[k]) begin
                    if (mc[k] < cmax[k]) mc[k]++;
                    if (mc[k] == cmax[k]) ms[k] = 1;
                    if (!movl[k]) start[k] = stream.size();
                end
            end
        end else begin
            for (int k = 0; k < 3; k++) mz[k] = 0;
        end
    endtask

    task automatic drive(input bit e, input bit b, input bit c,
                         input bit l = 1'b0, input logic [3:0] p = 4'b0);
        @(negedge clk);
        en = e; x = b; clr = c; pat_load = l; pat_in = p;
        @(posedge clk);
        model_edge(c, e, b, l, p);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({zv[k], cv[k], sv[k]} !== 10'b0) begin
                errors++;
                $display("FAIL reset dut%0d z/cnt/sat got %b/%0d/%b want 0/0/0", k, zv[k], cv[k], sv[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_match();
        bit s[9] = '{1, 1, 0, 1, 1, 1, 0, 1, 0};
        logic [8:0] zm = '0;
        drive(0, 0, 1);
        foreach (s[i]) begin
            drive(1, s[i], 0);
            zm[i] = z_a;
        end
        checks++;
        if (zm !== 9'b1_0000_0000 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL single_match zmask/cnt got %b/%0d want 100000000/1", zm, cnt_a);
        end
    endtask

    task automatic test_overlap();
        logic [5:0] zma = '0, zmb = '0;
        drive(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(1, (i % 2 == 0), 0);
            zma[i] = z_a;
            zmb[i] = z_b;
        end
        checks++;
        if (zma !== 6'b101000 || cnt_a !== 8'd2) begin
            errors++;
            $display("FAIL overlap_on zmask/cnt got %b/%0d want 101000/2", zma, cnt_a);
        end
        checks++;
        if (zmb !== 6'b001000 || cnt_b !== 8'd1) begin
            errors++;
            $display("FAIL overlap_off zmask/cnt got %b/%0d want 001000/1", zmb, cnt_b);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 1);
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 1, 0);
        @(negedge clk);
        en = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1, 0, 0);
        checks++;
        if (z_a !== 1'b0 || cnt_a !== 8'd0 || z_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid z_a/cnt_a/z_b got %b/%0d/%b want 0/0/0", z_a, cnt_a, z_b);
        end
    endtask

    task automatic test_en_gap();
        drive(0, 0, 1);
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(0, 1, 0);
        checks++;
        if (z_a !== 1'b0) begin
            errors++;
            $display("FAIL en_gap_idle z got %b want 0", z_a);
        end
        drive(0, 1, 0);
        drive(1, 1, 0);
        drive(1, 0, 0);
        checks++;
        if (z_a !== 1'b1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL en_gap z/cnt got %b/%0d want 1/1", z_a, cnt_a);
        end
        drive(0, 0, 0);
        checks++;
        if (z_a !== 1'b0 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL en_gap_pulse z/cnt got %b/%0d want 0/1", z_a, cnt_a);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] want_c[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bit         want_s[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit         grp[6]    = '{1, 0, 1, 0, 0, 0};
        drive(0, 0, 1);
        for (int m = 0; m < 5; m++) begin
            foreach (grp[i]) drive(1, grp[i], 0);
            checks++;
            if (cnt_c !== want_c[m] || sat_c !== want_s[m]) begin
                errors++;
                $display("FAIL saturate[%0d] cnt/sat got %0d/%b want %0d/%b", m, cnt_c, sat_c, want_c[m], want_s[m]);
            end
        end
        drive(0, 0, 1);
        checks++;
        if (cnt_c !== 2'd0 || sat_c !== 1'b0 || cnt_a !== 8'd0) begin
            errors++;
            $display("FAIL saturate_clr cnt_c/sat_c/cnt_a got %0d/%b/%0d want 0/0/0", cnt_c, sat_c, cnt_a);
        end
    endtask

`ifdef SEQ_DET_PATTERN_LOAD_EN
    task automatic test_pattern_load();
        drive(0, 0, 1);
        drive(1, 1, 0, 1, 4'b0110);
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive(1, 1, 0);
        drive(1, 0, 0);
        checks++;
        if (z_a !== 1'b1 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL pat_load_new z/cnt got %b/%0d want 1/1", z_a, cnt_a);
        end
        drive(1, 1, 0);
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive(1, 0, 0);
        checks++;
        if (z_a !== 1'b0 || cnt_a !== 8'd1) begin
            errors++;
            $display("FAIL pat_load_old z/cnt got %b/%0d want 0/1", z_a, cnt_a);
        end
        drive(0, 0, 0, 1, 4'b1010);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(99, 0) == 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (zv[k] !== mz[k] || cv[k] !== 8'(mc[k]) || sv[k] !== ms[k]) begin
                    errors++;
                    $display("FAIL random[%0d] dut%0d z/cnt/sat got %b/%0d/%b want %b/%0d/%b",
                             n, k, zv[k], cv[k], sv[k], mz[k], mc[k], ms[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 0, 1);
        for (int n = 0; n < 40; n++) begin
            drive(1, (n % 2 == 0), 0);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (zv[k] !== mz[k] || cv[k] !== 8'(mc[k]) || sv[k] !== ms[k]) begin
                    errors++;
                    $display("FAIL b2b[%0d] dut%0d z/cnt/sat got %b/%0d/%b want %b/%0d/%b",
                             n, k, zv[k], cv[k], sv[k], mz[k], mc[k], ms[k]);
                end
            end
        end
        checks++;
        if (cnt_a !== 8'd19 || cnt_b !== 8'd10) begin
            errors++;
            $display("FAIL b2b_totals cnt_a/cnt_b got %0d/%0d want 19/10", cnt_a, cnt_b);
        end
    endtask

    initial begin
        test_reset();
        test_single_match();
        test_overlap();
        test_reset_mid();
        test_en_gap();
        test_saturation();
`ifdef SEQ_DET_PATTERN_LOAD_EN
        test_pattern_load();
`endif
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
